// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers: FSM states,
// default bundle widths and the field layout every stage packs and unpacks.
package pipe_pkg;

  localparam int DATA_W_DEF = 107;
  localparam int CTRL_W_DEF = 9;
  localparam logic [CTRL_W_DEF-1:0] CTRL_BUBBLE_DEF = '0;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  // Data bundle layout (LSB offsets and widths).
  localparam int PC_LSB     = 0;
  localparam int PC_W       = 32;
  localparam int IMME_LSB   = 32;
  localparam int IMME_W     = 32;
  localparam int RDATA1_LSB = 64;
  localparam int RDATA1_W   = 32;
  localparam int RD_LSB     = 96;
  localparam int RD_W       = 5;
  localparam int FUNCT_LSB  = 101;
  localparam int FUNCT_W    = 6;

  // Control bundle layout.
  localparam int REGS_WRITE_BIT  = 0;
  localparam int ALUSRC_BIT      = 1;
  localparam int MEM_WRITE_BIT   = 2;
  localparam int MEM_READ_BIT    = 3;
  localparam int MEM_TO_REGS_BIT = 4;
  localparam int BRANCH_BIT      = 5;
  localparam int ALUOP_LSB       = 6;
  localparam int ALUOP_W         = 3;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry: valid flag plus data and control bundles, with
// load and clear controls (clear wins when both are asserted).
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int              DATA_W   = DATA_W_DEF,
  parameter int              CTRL_W   = CTRL_W_DEF,
  parameter logic [CTRL_W-1:0] CTRL_RST = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
    valid_d = valid_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      ctrl_d  = ctrl_i;
    end
  end

  // NOTE: the data bundle is reset too, because downstream must see zero data right after reset; a flush only drops valid.
  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so every flop samples the pre-edge values.
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= CTRL_RST;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign ctrl_o  = ctrl_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, stall, flush
// and an optional second (skid) entry that keeps in_ready_o registered.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W      = DATA_W_DEF,
  parameter int                CTRL_W      = CTRL_W_DEF,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = {CTRL_W{1'b0}},
  parameter int unsigned       SKID        = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CTRL_W-1:0] out_ctrl_o
);

  state_e            state_q, state_d;
  logic              ready_q, ready_d;
  logic              accept, take;
  logic              main_load, main_clear, main_sel_skid;
  logic              skid_load, skid_clear;
  logic              main_valid, skid_valid;
  logic [DATA_W-1:0] main_data, skid_data, main_in_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_in_ctrl;
  logic              unused_sig;

  assign accept = in_valid_i & in_ready_o;
  assign take   = main_valid & out_ready_i;

  always_comb begin
    state_d       = state_q;
    main_load     = 1'b0;
    main_clear    = 1'b0;
    main_sel_skid = 1'b0;
    skid_load     = 1'b0;
    skid_clear    = 1'b0;
    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d   = ST_FULL;
          main_load = 1'b1;
        end
      end
      ST_FULL: begin
        if (accept && take) begin
          main_load = 1'b1;
        end else if (accept) begin
          state_d   = ST_SKID;
          skid_load = 1'b1;
        end else if (take) begin
          state_d    = ST_EMPTY;
          main_clear = 1'b1;
        end
      end
      ST_SKID: begin
        if (take) begin
          state_d       = ST_FULL;
          main_load     = 1'b1;
          main_sel_skid = 1'b1;
          skid_clear    = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush overrides everything, including a beat accepted this cycle.
    if (flush_i) begin
      state_d       = ST_EMPTY;
      main_load     = 1'b0;
      main_sel_skid = 1'b0;
      main_clear    = 1'b1;
      skid_load     = 1'b0;
      skid_clear    = 1'b1;
    end
    ready_d = (state_d != ST_SKID);
  end

  // ready_q resets high so the stage is open as soon as reset releases;
  // the rst_n gate below keeps in_ready_o low while reset is held.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
    end
  end

  assign main_in_data = main_sel_skid ? skid_data : in_data_i;
  assign main_in_ctrl = main_sel_skid ? skid_ctrl : in_ctrl_i;

  pipe_slot #(
    .DATA_W  (DATA_W),
    .CTRL_W  (CTRL_W),
    .CTRL_RST(CTRL_BUBBLE)
  ) u_main (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (main_load),
    .clear_i(main_clear),
    .data_i (main_in_data),
    .ctrl_i (main_in_ctrl),
    .valid_o(main_valid),
    .data_o (main_data),
    .ctrl_o (main_ctrl)
  );

  generate
    if (SKID != 0) begin : g_skid
      pipe_slot #(
        .DATA_W  (DATA_W),
        .CTRL_W  (CTRL_W),
        .CTRL_RST(CTRL_BUBBLE)
      ) u_skid (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (skid_load),
        .clear_i(skid_clear),
        .data_i (in_data_i),
        .ctrl_i (in_ctrl_i),
        .valid_o(skid_valid),
        .data_o (skid_data),
        .ctrl_o (skid_ctrl)
      );
      assign in_ready_o = ready_q & rst_n;
      assign unused_sig = skid_valid;
    end else begin : g_no_skid
      // Single entry: a full stage can still accept when downstream drains it.
      assign skid_valid = 1'b0;
      assign skid_data  = '0;
      assign skid_ctrl  = '0;
      assign in_ready_o = rst_n & (~main_valid | out_ready_i);
      assign unused_sig = ^{skid_load, skid_clear, ready_q, skid_valid};
    end
  endgenerate

  assign out_valid_o = main_valid;
  assign out_data_o  = main_data;
  assign out_ctrl_o  = main_valid ? main_ctrl : CTRL_BUBBLE;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed vector table and hand sequences, then
// randomized traffic on SKID=1 and SKID=0 instances against queue models.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int DW = DATA_W_DEF;
  localparam int CW = CTRL_W_DEF;
  localparam logic [CW-1:0] BUB = '0;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          flush_1, in_valid_1, in_ready_1, out_valid_1, out_ready_1;
  logic [DW-1:0] in_data_1, out_data_1;
  logic [CW-1:0] in_ctrl_1, out_ctrl_1;
  logic          flush_0, in_valid_0, in_ready_0, out_valid_0, out_ready_0;
  logic [DW-1:0] in_data_0, out_data_0;
  logic [CW-1:0] in_ctrl_0, out_ctrl_0;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_BUBBLE(BUB), .SKID(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_1),
    .in_valid_i(in_valid_1), .in_ready_o(in_ready_1), .in_data_i(in_data_1), .in_ctrl_i(in_ctrl_1),
    .out_valid_o(out_valid_1), .out_ready_i(out_ready_1), .out_data_o(out_data_1), .out_ctrl_o(out_ctrl_1)
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_BUBBLE(BUB), .SKID(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_0),
    .in_valid_i(in_valid_0), .in_ready_o(in_ready_0), .in_data_i(in_data_0), .in_ctrl_i(in_ctrl_0),
    .out_valid_o(out_valid_0), .out_ready_i(out_ready_0), .out_data_o(out_data_0), .out_ctrl_o(out_ctrl_0)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_dut(input string tag,
                           input logic act_v, input logic act_r,
                           input logic [DW-1:0] act_d, input logic [CW-1:0] act_c,
                           input logic exp_v, input logic exp_r,
                           input logic [DW-1:0] exp_d, input logic [CW-1:0] exp_c);
    check({tag, " out_valid"}, 128'(act_v), 128'(exp_v));
    check({tag, " in_ready"}, 128'(act_r), 128'(exp_r));
    if (exp_v) begin
      check({tag, " out_data"}, 128'(act_d), 128'(exp_d));
      check({tag, " out_ctrl"}, 128'(act_c), 128'(exp_c));
    end else begin
      check({tag, " bubble ctrl"}, 128'(act_c), 128'(BUB));
    end
  endtask

  function automatic logic [CW-1:0] ctrl_of(input int unsigned d);
    return CW'(d * 3 + 1);
  endfunction

  typedef struct {
    logic        v, r, f;
    int unsigned d;
    logic        ev, er;
    int unsigned ed;
  } vec_t;
  vec_t tab[$];

  function automatic void add(input logic v, input logic r, input logic f, input int unsigned d,
                              input logic ev, input logic er, input int unsigned ed);
    vec_t x;
    x.v = v; x.r = r; x.f = f; x.d = d; x.ev = ev; x.er = er; x.ed = ed;
    tab.push_back(x);
  endfunction

  typedef struct {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } beat_t;
  beat_t q1[$];
  beat_t q0[$];

  logic [127:0] rnd;

  initial begin
    logic  m_v1, m_r1, m_v0, m_r0, acc1, acc0, tk1, tk0;
    beat_t h1, h0, nb;

    rst_n = 1'b0;
    flush_1 = 1'b0; in_valid_1 = 1'b1; out_ready_1 = 1'b1; in_data_1 = DW'(32'h77); in_ctrl_1 = ctrl_of(32'h77);
    flush_0 = 1'b0; in_valid_0 = 1'b1; out_ready_0 = 1'b1; in_data_0 = DW'(32'h77); in_ctrl_0 = ctrl_of(32'h77);

    // Reset held two cycles with traffic offered.
    repeat (2) begin
      @(posedge clk); #1;
      check_dut("reset skid1", out_valid_1, in_ready_1, out_data_1, out_ctrl_1, 1'b0, 1'b0, '0, BUB);
      check("reset skid1 out_data", 128'(out_data_1), 128'(0));
      check_dut("reset skid0", out_valid_0, in_ready_0, out_data_0, out_ctrl_0, 1'b0, 1'b0, '0, BUB);
      check("reset skid0 out_data", 128'(out_data_0), 128'(0));
    end
    rst_n = 1'b1;
    in_valid_1 = 1'b0;
    in_valid_0 = 1'b0;
    #1;
    check("ready after reset skid1", 128'(in_ready_1), 128'(1));
    check("ready after reset skid0", 128'(in_ready_0), 128'(1));

    // Directed table on the SKID=1 instance: streaming, stall, flush.
    for (int k = 1; k <= 8; k++) add(1, 1, 0, k, 1, 1, k);
    add(0, 1, 0, 0, 0, 1, 0);
    add(1, 1, 0, 5, 1, 1, 5);
    add(1, 0, 0, 6, 1, 0, 5);
    add(1, 0, 0, 7, 1, 0, 5);
    add(1, 1, 0, 7, 1, 1, 6);
    add(1, 1, 0, 7, 1, 1, 7);
    add(0, 1, 0, 0, 0, 1, 0);
    add(1, 0, 0, 10, 1, 1, 10);
    add(1, 0, 0, 11, 1, 0, 10);
    add(1, 0, 1, 9, 0, 1, 0);
    add(0, 1, 0, 0, 0, 1, 0);
    add(1, 1, 0, 12, 1, 1, 12);
    add(1, 1, 1, 13, 0, 1, 0);
    add(0, 1, 0, 0, 0, 1, 0);

    for (int i = 0; i < tab.size(); i++) begin
      in_valid_1  = tab[i].v;
      out_ready_1 = tab[i].r;
      flush_1     = tab[i].f;
      in_data_1   = DW'(tab[i].d);
      in_ctrl_1   = ctrl_of(tab[i].d);
      @(posedge clk); #1;
      check_dut($sformatf("vec%0d", i), out_valid_1, in_ready_1, out_data_1, out_ctrl_1,
                tab[i].ev, tab[i].er, DW'(tab[i].ed), ctrl_of(tab[i].ed));
    end
    in_valid_1 = 1'b0;
    flush_1    = 1'b0;

    // SKID=0 stall: in_ready drops combinationally, outputs stay put.
    in_valid_0 = 1'b1; out_ready_0 = 1'b1; in_data_0 = DW'(20); in_ctrl_0 = ctrl_of(20);
    @(posedge clk); #1;
    check_dut("s0 load", out_valid_0, in_ready_0, out_data_0, out_ctrl_0, 1'b1, 1'b1, DW'(20), ctrl_of(20));
    out_ready_0 = 1'b0; in_data_0 = DW'(21); in_ctrl_0 = ctrl_of(21);
    #1;
    check("s0 ready same cycle", 128'(in_ready_0), 128'(0));
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check_dut($sformatf("s0 stall%0d", i), out_valid_0, in_ready_0, out_data_0, out_ctrl_0,
                1'b1, 1'b0, DW'(20), ctrl_of(20));
    end
    out_ready_0 = 1'b1;
    #1;
    check("s0 ready release", 128'(in_ready_0), 128'(1));
    @(posedge clk); #1;
    check_dut("s0 next", out_valid_0, in_ready_0, out_data_0, out_ctrl_0, 1'b1, 1'b1, DW'(21), ctrl_of(21));
    in_valid_0 = 1'b0;
    @(posedge clk); #1;
    check_dut("s0 drain", out_valid_0, in_ready_0, out_data_0, out_ctrl_0, 1'b0, 1'b1, '0, BUB);

    // Random traffic against queue models; the first cycle starts in reset.
    rst_n = 1'b0;
    @(posedge clk); #1;
    q1.delete();
    q0.delete();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      rst_n       = ($urandom_range(0, 499) != 0);
      in_valid_1  = ($urandom_range(0, 9) < 7);
      out_ready_1 = ($urandom_range(0, 9) < 6);
      flush_1     = ($urandom_range(0, 49) == 0);
      rnd         = {$urandom, $urandom, $urandom, $urandom};
      in_data_1   = rnd[DW-1:0];
      in_ctrl_1   = CW'($urandom);
      in_valid_0  = ($urandom_range(0, 9) < 7);
      out_ready_0 = ($urandom_range(0, 9) < 6);
      flush_0     = ($urandom_range(0, 49) == 0);
      rnd         = {$urandom, $urandom, $urandom, $urandom};
      in_data_0   = rnd[DW-1:0];
      in_ctrl_0   = CW'($urandom);
      #1;
      m_v1 = (q1.size() > 0);
      m_r1 = rst_n && (q1.size() < 2);
      m_v0 = (q0.size() > 0);
      m_r0 = rst_n && (q0.size() == 0 || out_ready_0);
      h1 = m_v1 ? q1[0] : '{d: '0, c: '0};
      h0 = m_v0 ? q0[0] : '{d: '0, c: '0};
      check_dut("rnd skid1", out_valid_1, in_ready_1, out_data_1, out_ctrl_1, m_v1, m_r1, h1.d, h1.c);
      check_dut("rnd skid0", out_valid_0, in_ready_0, out_data_0, out_ctrl_0, m_v0, m_r0, h0.d, h0.c);
      acc1 = in_valid_1 && m_r1;
      tk1  = m_v1 && out_ready_1;
      acc0 = in_valid_0 && m_r0;
      tk0  = m_v0 && out_ready_0;
      @(posedge clk);
      if (!rst_n || flush_1) q1.delete();
      else begin
        if (tk1) void'(q1.pop_front());
        if (acc1) begin nb.d = in_data_1; nb.c = in_ctrl_1; q1.push_back(nb); end
      end
      if (!rst_n || flush_0) q0.delete();
      else begin
        if (tk0) void'(q0.pop_front());
        if (acc0) begin nb.d = in_data_0; nb.c = in_ctrl_0; q0.push_back(nb); end
      end
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
